// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT sequencer state encoding and default transform size
package fft_pkg;
    localparam int LOG2N_DEF = 3;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, NEXT, DONE} state_t;
endpackage

// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: control and butterfly handshake bundle of the FFT sequencer
interface fft_stage_sequencer_if #(parameter int LOG2N = fft_pkg::LOG2N_DEF);
    localparam int SW = $clog2(LOG2N);
    logic             start;
    logic             flush;
    logic             bf_valid;
    logic             bf_ready;
    logic             bf_done;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             wr_en;
    logic [SW-1:0]    stage;
    logic             busy;
    logic             done;
    modport master (
        input  start, flush, bf_ready, bf_done,
        output bf_valid, addr_a, addr_b, tw_idx, wr_en, stage, busy, done
    );
    modport slave (
        output start, flush, bf_ready, bf_done,
        input  bf_valid, addr_a, addr_b, tw_idx, wr_en, stage, busy, done
    );
endinterface

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: radix-2 DIT operand addresses and twiddle index for stage s, butterfly j
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF,
    localparam int SW = $clog2(LOG2N),
    localparam int TW = LOG2N - 1
) (
    input  logic [SW-1:0]    s,
    input  logic [TW-1:0]    j,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [TW-1:0]    tw_idx
);
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    // group base is j with its low s bits cleared, doubled; pos is the offset inside the group
    always_comb begin
        half   = LOG2N'(1) << s;
        pos    = {1'b0, j} & (half - LOG2N'(1));
        addr_a = ((({1'b0, j} >> s) << s) << 1) | pos;
        addr_b = addr_a + half;
        tw_idx = TW'(pos << (LOG2N - 1 - int'(s)));
    end
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks all stages/butterflies of an in-place N-point DIT FFT
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEF
) (
    input logic                  Clock,
    input logic                  nReset,
    fft_stage_sequencer_if.master bus
);
    localparam int SW = $clog2(LOG2N);
    localparam int JW = LOG2N - 1;

    state_t           state_q;
    logic [SW-1:0]    s_q, s_d;
    logic [JW-1:0]    j_q, j_d;
    logic [LOG2N-1:0] a_q, b_q, gen_a, gen_b;
    logic [JW-1:0]    tw_q, gen_tw;
    logic             valid_q, wr_q, busy_q, done_q;
    logic             j_last, s_last;

    // next butterfly coordinates: zero when launching from IDLE, else j+1 with stage carry
    always_comb begin
        j_last = &j_q;
        s_last = s_q == SW'(LOG2N - 1);
        j_d    = (state_q == IDLE) ? '0 : j_q + 1'b1;
        s_d    = (state_q == IDLE) ? '0 : s_q + SW'(j_last);
    end

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr (
        .s      (s_d),
        .j      (j_d),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // sequencer FSM; addresses are latched on ISSUE entry so they hold through WRITE
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tw_q    <= '0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= ISSUE;
                    s_q     <= s_d;
                    j_q     <= j_d;
                    a_q     <= gen_a;
                    b_q     <= gen_b;
                    tw_q    <= gen_tw;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                ISSUE: if (bus.bf_ready) begin
                    state_q <= WAIT;
                    valid_q <= 1'b0;
                end
                WAIT: if (bus.bf_done) begin
                    state_q <= WRITE;
                    wr_q    <= 1'b1;
                end
                WRITE: begin
                    state_q <= NEXT;
                    wr_q    <= 1'b0;
                end
                NEXT: if (s_last && j_last) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end else begin
                    state_q <= ISSUE;
                    s_q     <= s_d;
                    j_q     <= j_d;
                    a_q     <= gen_a;
                    b_q     <= gen_b;
                    tw_q    <= gen_tw;
                    valid_q <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bf_valid = valid_q;
    assign bus.addr_a   = a_q;
    assign bus.addr_b   = b_q;
    assign bus.tw_idx   = tw_q;
    assign bus.wr_en    = wr_q;
    assign bus.stage    = s_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed, table-driven checks of the FFT stage sequencer
module tb_fft_stage_sequencer;
    typedef struct {int a; int b; int tw; int st;} rec_t;

    logic Clock   = 1'b0;
    logic nReset  = 1'b0;
    logic auto_rdy = 1'b1;
    logic man_rdy  = 1'b0;
    logic auto_dn  = 1'b1;
    logic man_dn   = 1'b0;
    logic acc3     = 1'b0;
    logic acc4     = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   dn3 = 0;
    int   dn4 = 0;
    rec_t log3[$];
    rec_t log4[$];
    rec_t exp3[12];

    fft_stage_sequencer_if #(.LOG2N(3)) b3();
    fft_stage_sequencer_if #(.LOG2N(4)) b4();

    fft_stage_sequencer #(.LOG2N(3)) dut3 (.Clock(Clock), .nReset(nReset), .bus(b3));
    fft_stage_sequencer #(.LOG2N(4)) dut4 (.Clock(Clock), .nReset(nReset), .bus(b4));

    always #5 Clock = ~Clock;

    assign b3.bf_ready = auto_rdy ? 1'b1 : man_rdy;
    assign b3.bf_done  = auto_dn ? acc3 : man_dn;
    assign b4.bf_ready = 1'b1;
    assign b4.bf_done  = acc4;

    // butterfly model: result pulse one cycle after operand acceptance
    always @(posedge Clock) begin
        acc3 <= b3.bf_valid & b3.bf_ready;
        acc4 <= b4.bf_valid & b4.bf_ready;
    end

    // write-back and done monitors
    always @(negedge Clock) begin
        if (b3.wr_en) log3.push_back(rec_t'{int'(b3.addr_a), int'(b3.addr_b), int'(b3.tw_idx), int'(b3.stage)});
        if (b4.wr_en) log4.push_back(rec_t'{int'(b4.addr_a), int'(b4.addr_b), int'(b4.tw_idx), int'(b4.stage)});
        if (b3.done) dn3++;
        if (b4.done) dn4++;
    end

    task automatic tick();
        @(negedge Clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rec(input string nm, input rec_t act, input rec_t exp);
        chk({nm, "_a"}, act.a, exp.a);
        chk({nm, "_b"}, act.b, exp.b);
        chk({nm, "_tw"}, act.tw, exp.tw);
        chk({nm, "_stage"}, act.st, exp.st);
    endtask

    task automatic pulse3();
        b3.start = 1'b1;
        tick();
        b3.start = 1'b0;
    endtask

    task automatic wait3(input int maxc);
        int n = 0;
        while (!b3.done && n < maxc) begin
            tick();
            n++;
        end
        chk("done3_seen", int'(b3.done), 1);
    endtask

    initial begin
        int base, d0, n;
        logic [2:0] a0, bb0;
        logic [1:0] t0;
        exp3 = '{'{0,1,0,0}, '{2,3,0,0}, '{4,5,0,0}, '{6,7,0,0},
                 '{0,2,0,1}, '{1,3,2,1}, '{4,6,0,1}, '{5,7,2,1},
                 '{0,4,0,2}, '{1,5,1,2}, '{2,6,2,2}, '{3,7,3,2}};
        b3.start = 1'b0; b3.flush = 1'b0;
        b4.start = 1'b0; b4.flush = 1'b0;

        tick(); tick();
        chk("rst_valid", int'(b3.bf_valid), 0);
        chk("rst_wr_en", int'(b3.wr_en), 0);
        chk("rst_busy", int'(b3.busy), 0);
        chk("rst_done", int'(b3.done), 0);
        chk("rst_addr_a", int'(b3.addr_a), 0);
        chk("rst_addr_b", int'(b3.addr_b), 0);
        chk("rst_tw", int'(b3.tw_idx), 0);
        chk("rst_stage", int'(b3.stage), 0);
        nReset = 1'b1;
        tick();

        // full uninterrupted run against the expected write-back table
        base = log3.size(); d0 = dn3;
        pulse3();
        chk("run_busy_start", int'(b3.busy), 1);
        wait3(200);
        chk("run_busy_in_done", int'(b3.busy), 1);
        tick();
        chk("run_busy_after", int'(b3.busy), 0);
        chk("run_writes", log3.size() - base, 12);
        chk("run_done_pulses", dn3 - d0, 1);
        for (int i = 0; i < 12; i++) chk_rec($sformatf("run_w%0d", i), log3[base + i], exp3[i]);

        // stalled ISSUE with spurious bf_done and start pulses while busy
        auto_rdy = 1'b0; man_rdy = 1'b0; auto_dn = 1'b0; man_dn = 1'b0;
        base = log3.size(); d0 = dn3;
        pulse3();
        a0 = b3.addr_a; bb0 = b3.addr_b; t0 = b3.tw_idx;
        chk("hold_first_a", int'(a0), 0);
        chk("hold_first_b", int'(bb0), 1);
        for (int i = 0; i < 5; i++) begin
            man_dn = (i == 1);
            b3.start = (i == 3);
            tick();
            chk($sformatf("hold%0d_valid", i), int'(b3.bf_valid), 1);
            chk($sformatf("hold%0d_a", i), int'(b3.addr_a), int'(a0));
            chk($sformatf("hold%0d_b", i), int'(b3.addr_b), int'(bb0));
            chk($sformatf("hold%0d_tw", i), int'(b3.tw_idx), int'(t0));
        end
        man_dn = 1'b0; b3.start = 1'b0;
        chk("hold_no_write", log3.size() - base, 0);
        auto_rdy = 1'b1; auto_dn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            b3.start = (i == 6);
            tick();
        end
        b3.start = 1'b0;
        wait3(200);
        tick();
        chk("hold_writes", log3.size() - base, 12);
        chk("hold_done_pulses", dn3 - d0, 1);
        for (int i = 0; i < 4; i++) tick();
        chk("hold_no_restart", int'(b3.busy), 0);
        chk("hold_writes_final", log3.size() - base, 12);

        // flush in WAIT at stage 1, j=2
        base = log3.size(); d0 = dn3;
        pulse3();
        n = 0;
        while (!(b3.bf_valid && log3.size() - base == 6) && n < 200) begin
            tick();
            n++;
        end
        chk("fl_reach_issue", int'(b3.bf_valid), 1);
        chk("fl_a", int'(b3.addr_a), 4);
        chk("fl_b", int'(b3.addr_b), 6);
        chk("fl_stage", int'(b3.stage), 1);
        tick();
        chk("fl_in_wait", int'(b3.bf_valid), 0);
        b3.flush = 1'b1;
        tick();
        b3.flush = 1'b0;
        chk("fl_busy", int'(b3.busy), 0);
        chk("fl_wr_en", int'(b3.wr_en), 0);
        for (int i = 0; i < 5; i++) tick();
        chk("fl_writes", log3.size() - base, 6);
        chk("fl_no_done", dn3 - d0, 0);
        base = log3.size();
        pulse3();
        wait3(200);
        tick();
        chk("fl_replay_writes", log3.size() - base, 12);
        chk_rec("fl_replay_w0", log3[base], exp3[0]);

        // asynchronous reset during WRITE
        base = log3.size();
        pulse3();
        n = 0;
        while (!b3.wr_en && n < 50) begin
            tick();
            n++;
        end
        chk("rs_reach_write", int'(b3.wr_en), 1);
        #1 nReset = 1'b0;
        #1;
        chk("rs_wr_en", int'(b3.wr_en), 0);
        chk("rs_busy", int'(b3.busy), 0);
        chk("rs_stage", int'(b3.stage), 0);
        tick();
        nReset = 1'b1;
        tick();
        base = log3.size();
        pulse3();
        wait3(200);
        tick();
        chk("rs_restart_writes", log3.size() - base, 12);
        chk_rec("rs_restart_w0", log3[base], exp3[0]);

        // LOG2N=4 run
        base = log4.size(); d0 = dn4;
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        n = 0;
        while (!b4.done && n < 400) begin
            tick();
            n++;
        end
        chk("n16_done_seen", int'(b4.done), 1);
        tick();
        chk("n16_writes", log4.size() - base, 32);
        chk("n16_done_pulses", dn4 - d0, 1);
        chk("n16_busy_after", int'(b4.busy), 0);
        chk_rec("n16_first", log4[base], rec_t'{0, 1, 0, 0});
        chk_rec("n16_last", log4[base + 31], rec_t'{7, 15, 7, 3});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_stage_sequencer.md
FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

Interface
REQ-001 SHALL have parameter LOG2N, default 3, meaning log2 of FFT points N (legal 2..10).
REQ-002 SHALL have port Clock  input  1  single rising-edge clock.
REQ-003 SHALL have port nReset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to run a full in-place N-point DIT FFT.
REQ-005 SHALL have port flush  input  1  synchronous abort of the current run.
REQ-006 SHALL have port bf_valid  output  1  butterfly operand pair is presented.
REQ-007 SHALL have port bf_ready  input  1  butterfly accepts operands this cycle.
REQ-008 SHALL have port bf_done  input  1  one-cycle pulse, butterfly results available.
REQ-009 SHALL have port addr_a / addr_b  output  LOG2N each  memory addresses of the upper and lower operands.
REQ-010 SHALL have port tw_idx  output  LOG2N-1  twiddle ROM index, W_N^tw_idx.
REQ-011 SHALL have port wr_en  output  1  write results back to addr_a/addr_b.
REQ-012 SHALL have port stage  output  ceil(log2(LOG2N))  current stage number.
REQ-013 SHALL have port busy  output  1  high from acceptance of start until the DONE state is left.
REQ-014 SHALL have port done  output  1  one-cycle pulse at the end of the run.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, WRITE, NEXT, DONE.
REQ-016 SHALL move IDLE->ISSUE when start=1 and clear stage counter s and butterfly counter j to 0.
REQ-017 SHALL hold bf_valid=1 in ISSUE and move to WAIT on the cycle where bf_ready=1.
REQ-018 SHALL keep addr_a, addr_b and tw_idx stable from ISSUE entry until WRITE exit.
REQ-019 SHALL move WAIT->WRITE on bf_done=1; a bf_done seen in any other state SHALL be ignored.
REQ-020 SHALL assert wr_en for exactly the one WRITE cycle, then move to NEXT.
REQ-021 SHALL in NEXT increment j; at j=N/2-1 set j=0 and increment s; at s=LOG2N-1 and j=N/2-1 go to DONE, else go to ISSUE.
REQ-022 SHALL with half=2^s, pos=j mod half, grp=j>>s compute addr_a=grp*2*half+pos, addr_b=addr_a+half, tw_idx=pos<<(LOG2N-1-s).
REQ-023 SHALL assert done for the single DONE cycle, then return to IDLE.
REQ-024 SHALL ignore start in every state except IDLE.
REQ-025 SHALL on flush=1 go to IDLE next cycle from any state, with no wr_en in that cycle; flush SHALL take priority over start, bf_ready and bf_done.
REQ-026 SHALL perform exactly (N/2)*LOG2N write-backs per uninterrupted run.
REQ-027 SHALL drive outputs from registered state, with no combinational path from any input to any output.

Reset
REQ-028 SHALL on nReset=0 immediately enter IDLE with s=0, j=0, bf_valid=0, wr_en=0, busy=0, done=0, addr_a=0, addr_b=0, tw_idx=0.
REQ-029 SHALL leave no partial write when reset is asserted mid-run; the first start after release SHALL begin at s=0, j=0.

Structure
REQ-030 SHALL take the state enum and the default LOG2N from shared package fft_pkg.
REQ-031 SHALL place the REQ-022 address/twiddle mapping in combinational sub-module fft_addr_gen (inputs s and j; outputs addr_a, addr_b, tw_idx).

Verification
REQ-032 SHALL check, at LOG2N=3 with bf_ready tied 1 and bf_done one cycle after acceptance: start -> 12 wr_en pulses; the (a,b,tw) sequence starts (0,1,0),(2,3,0); stage1 j=1 gives (1,3,2); stage1 j=2 gives (4,6,0); stage2 j=3 gives (3,7,3); then one done pulse and busy falls.
REQ-033 SHALL check bf_ready held 0 for 5 cycles in ISSUE -> bf_valid stays 1 and addresses stay constant, with no state advance.
REQ-034 SHALL check flush asserted in WAIT at stage1 j=2 -> IDLE next cycle, no wr_en and no done; the next start replays from (0,1,0).
REQ-035 SHALL check start pulses while busy and a spurious bf_done in ISSUE -> both ignored and the total write-back count stays 12.
REQ-036 SHALL check nReset asserted mid-WRITE -> wr_en=0 and busy=0 immediately, without waiting for a clock edge.
REQ-037 SHALL check LOG2N=4 -> 32 write-backs; the last is (7,15,7) at stage 3.
